// File: rtl/breakout_render_pkg.sv
// Geometry shared with the game logic, and the 8x8 ball sprite used by every ball.
package breakout_render_pkg;

  localparam int TILE_BITS       = 3;
  localparam int BLOCK_W_TILES_D = 8;
  localparam int BLOCK_H_TILES_D = 2;
  localparam int GRID_X_TILE_D   = 5;
  localparam int GRID_Y_TILE_D   = 8;
  localparam int PADDLE_Y_TILE_D = 72;
  localparam int PADDLE_LEN_D    = 64;
  localparam int LEFT_WALL_D     = 4;
  localparam int RIGHT_WALL_D    = 95;
  localparam int CEIL_TILE_D     = 6;

  // Row r of the round mask lives at bits [8r+7:8r]; bit c is column c.
  localparam logic [63:0] BALL_SPRITE = 64'h3C7E_FFFF_FFFF_7E3C;

  function automatic logic spriteBit(input logic [2:0] row, input logic [2:0] col);
    return BALL_SPRITE[{row, col}];
  endfunction

endpackage

// File: rtl/breakout_ball_hit.sv
// Hit test of one pixel against one ball sprite at its frame-shadowed position.
module breakout_ball_hit
  import breakout_render_pkg::*;
(
  input  logic       en,
  input  logic [9:0] ballX,
  input  logic [9:0] ballY,
  input  logic [9:0] xPixel,
  input  logic [9:0] yPixel,
  output logic       hit
);

  logic [9:0] dx;
  logic [9:0] dy;

  // Modulo-1024 offsets: only 0..7 in both axes lands inside the sprite box.
  assign dx  = xPixel - ballX;
  assign dy  = yPixel - ballY;
  assign hit = en && (dx[9:3] == 7'd0) && (dy[9:3] == 7'd0) && spriteBit(dy[2:0], dx[2:0]);

endmodule

// File: rtl/breakout_layer_renderer.sv
// Two-stage compositor: stage 0 addresses the block RAM, stage 1 layers balls,
// paddle, housing and blocks into COLOR, with syncs delayed to match.
module breakout_layer_renderer
  import breakout_render_pkg::*;
#(
  parameter int          COLS            = 10,
  parameter int          ROWS            = 7,
  parameter int          NUM_BALLS       = 1,
  parameter int          ADDR_W          = 7,
  parameter int          BLOCK_W_TILES   = BLOCK_W_TILES_D,
  parameter int          BLOCK_H_TILES   = BLOCK_H_TILES_D,
  parameter int          GRID_X_TILE     = GRID_X_TILE_D,
  parameter int          GRID_Y_TILE     = GRID_Y_TILE_D,
  parameter int          PADDLE_Y_TILE   = PADDLE_Y_TILE_D,
  parameter int          PADDLE_LEN      = PADDLE_LEN_D,
  parameter int          LEFT_WALL_TILE  = LEFT_WALL_D,
  parameter int          RIGHT_WALL_TILE = RIGHT_WALL_D,
  parameter int          CEIL_TILE       = CEIL_TILE_D,
  parameter int          SCREEN_H        = 600,
  parameter logic [7:0]  FG_COLOR        = 8'hFF
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [10:0]             X_PIXEL,
  input  logic [9:0]              Y_PIXEL,
  input  logic                    HSYNC_IN,
  input  logic                    VSYNC_IN,
  input  logic [9:0]              PADDLE_X_PIXEL,
  input  logic [10*NUM_BALLS-1:0] BALL_X_PIXEL,
  input  logic [10*NUM_BALLS-1:0] BALL_Y_PIXEL,
  input  logic [NUM_BALLS-1:0]    BALL_EN,
  input  logic [8*ROWS-1:0]       ROW_COLORS,
  output logic [ADDR_W-1:0]       BLOCK_ADDR,
  input  logic                    BLOCK_ALIVE,
  output logic                    FRAME_DONE,
  output logic [7:0]              COLOR,
  output logic                    HSYNC,
  output logic                    VSYNC
);

  logic [9:0]              paddleXSh;
  logic [10*NUM_BALLS-1:0] ballXSh;
  logic [10*NUM_BALLS-1:0] ballYSh;
  logic [NUM_BALLS-1:0]    ballEnSh;
  logic [8*ROWS-1:0]       rowColorsSh;

  logic [7:0]        xTile0;
  logic [6:0]        yTile0;
  logic [7:0]        colFull;
  logic [6:0]        rowFull;
  logic              inGrid0;
  logic [ADDR_W-1:0] addr0;
  logic              frameStart;

  logic [10:0] x1;
  logic [9:0]  y1;
  logic        inGrid1;
  logic [2:0]  row1;
  logic        hs1;
  logic        vs1;

  assign xTile0     = X_PIXEL[10:TILE_BITS];
  assign yTile0     = Y_PIXEL[9:TILE_BITS];
  // Unsigned wrap sends pixels left of / above the grid to huge col/row values.
  assign colFull    = (xTile0 - 8'(GRID_X_TILE)) / 8'(BLOCK_W_TILES);
  assign rowFull    = (yTile0 - 7'(GRID_Y_TILE)) / 7'(BLOCK_H_TILES);
  assign inGrid0    = (colFull < 8'(COLS)) && (rowFull < 7'(ROWS));
  assign addr0      = ADDR_W'(int'(rowFull) * COLS + int'(colFull));
  assign frameStart = (X_PIXEL == 11'd0) && (Y_PIXEL == 10'd0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      paddleXSh   <= '0;
      ballXSh     <= '0;
      ballYSh     <= '0;
      ballEnSh    <= '0;
      rowColorsSh <= '0;
      BLOCK_ADDR  <= '0;
      FRAME_DONE  <= 1'b0;
      x1          <= '0;
      y1          <= '0;
      inGrid1     <= 1'b0;
      row1        <= '0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
    end else begin
      if (frameStart) begin
        paddleXSh   <= PADDLE_X_PIXEL;
        ballXSh     <= BALL_X_PIXEL;
        ballYSh     <= BALL_Y_PIXEL;
        ballEnSh    <= BALL_EN;
        rowColorsSh <= ROW_COLORS;
      end
      BLOCK_ADDR <= inGrid0 ? addr0 : '0;
      FRAME_DONE <= (X_PIXEL == 11'd0) && (Y_PIXEL == 10'(SCREEN_H));
      x1         <= X_PIXEL;
      y1         <= Y_PIXEL;
      inGrid1    <= inGrid0;
      row1       <= inGrid0 ? rowFull[2:0] : 3'd0;
      hs1        <= HSYNC_IN;
      vs1        <= VSYNC_IN;
    end
  end

  logic [7:0]           xTile1;
  logic [6:0]           yTile1;
  logic                 inHousing;
  logic                 inPaddle;
  logic                 inBlock;
  logic [NUM_BALLS-1:0] ballHit;
  logic [63:0]          rowColorsPad;
  logic [7:0]           colorNext;

  assign xTile1    = x1[10:TILE_BITS];
  assign yTile1    = y1[9:TILE_BITS];
  assign inBlock   = inGrid1 && BLOCK_ALIVE;
  assign inHousing = ((yTile1 == 7'(CEIL_TILE)) &&
                      (xTile1 >= 8'(LEFT_WALL_TILE)) && (xTile1 <= 8'(RIGHT_WALL_TILE))) ||
                     ((yTile1 > 7'(CEIL_TILE)) &&
                      ((xTile1 == 8'(LEFT_WALL_TILE)) || (xTile1 == 8'(RIGHT_WALL_TILE))));
  // 11-bit compare so a paddle near x=1023 does not wrap onto the left edge.
  assign inPaddle  = (yTile1 == 7'(PADDLE_Y_TILE)) &&
                     (x1 >= {1'b0, paddleXSh}) &&
                     (x1 < ({1'b0, paddleXSh} + 11'(PADDLE_LEN)));
  assign rowColorsPad = 64'(rowColorsSh);

  for (genvar g = 0; g < NUM_BALLS; g++) begin : gBall
    breakout_ball_hit uHit (
      .en    (ballEnSh[g]),
      .ballX (ballXSh[10*g +: 10]),
      .ballY (ballYSh[10*g +: 10]),
      .xPixel(x1[9:0]),
      .yPixel(y1),
      .hit   (ballHit[g])
    );
  end

  always_comb begin
    colorNext = 8'd0;
    if ((|ballHit) || inPaddle || inHousing) begin
      colorNext = FG_COLOR;
    end else if (inBlock) begin
      colorNext = rowColorsPad[{row1, 3'b000} +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      COLOR <= 8'd0;
      HSYNC <= 1'b0;
      VSYNC <= 1'b0;
    end else begin
      COLOR <= colorNext;
      HSYNC <= hs1;
      VSYNC <= vs1;
    end
  end

endmodule

// File: tb/tb_breakout_layer_renderer.sv
// Randomised bench for breakout_layer_renderer with two balls, checked against a geometric model.
module tb_breakout_layer_renderer;

  localparam int NB = 2;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [10:0]   X_PIXEL;
  logic [9:0]    Y_PIXEL;
  logic          HSYNC_IN, VSYNC_IN;
  logic [9:0]    PADDLE_X_PIXEL;
  logic [10*NB-1:0] BALL_X_PIXEL, BALL_Y_PIXEL;
  logic [NB-1:0] BALL_EN;
  logic [55:0]   ROW_COLORS;
  logic [6:0]    BLOCK_ADDR;
  logic          BLOCK_ALIVE;
  logic          FRAME_DONE;
  logic [7:0]    COLOR;
  logic          HSYNC, VSYNC;

  logic [127:0]  ram_bits;
  assign BLOCK_ALIVE = ram_bits[BLOCK_ADDR];

  breakout_layer_renderer #(.NUM_BALLS(NB)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .X_PIXEL(X_PIXEL), .Y_PIXEL(Y_PIXEL),
    .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN), .PADDLE_X_PIXEL(PADDLE_X_PIXEL),
    .BALL_X_PIXEL(BALL_X_PIXEL), .BALL_Y_PIXEL(BALL_Y_PIXEL), .BALL_EN(BALL_EN),
    .ROW_COLORS(ROW_COLORS), .BLOCK_ADDR(BLOCK_ADDR), .BLOCK_ALIVE(BLOCK_ALIVE),
    .FRAME_DONE(FRAME_DONE), .COLOR(COLOR), .HSYNC(HSYNC), .VSYNC(VSYNC)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];   // {vsync, hsync, color}, latency 2
  logic [7:0] exp1_q[$];  // {frame_done, block_addr}, latency 1

  int sh_px;
  int sh_bx[NB];
  int sh_by[NB];
  bit sh_en[NB];
  int sh_rc[7];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Ball sprite as a disc of radius ~3.8 centred in the 8x8 box.
  function automatic bit ball_px(int x, int y, int bx, int by);
    int dx, dy;
    dx = (x - bx) & 1023;
    dy = (y - by) & 1023;
    if (dx >= 8 || dy >= 8) return 1'b0;
    return ((2*dx-7)*(2*dx-7) + (2*dy-7)*(2*dy-7)) <= 58;
  endfunction

  function automatic int grid_addr(int x, int y);
    int xt, yt, col, row;
    xt = x / 8; yt = y / 8;
    if (xt < 5 || yt < 8) return -1;
    col = (xt - 5) / 8;
    row = (yt - 8) / 2;
    if (col >= 10 || row >= 7) return -1;
    return row * 10 + col;
  endfunction

  function automatic logic [7:0] model_color(int x, int y);
    int xt, yt, a;
    xt = x / 8; yt = y / 8;
    for (int i = 0; i < NB; i++)
      if (sh_en[i] && ball_px(x, y, sh_bx[i], sh_by[i])) return 8'hFF;
    if (yt == 72 && x >= sh_px && x < sh_px + 64) return 8'hFF;
    if (yt == 6 && xt >= 4 && xt <= 95) return 8'hFF;
    if (yt > 6 && (xt == 4 || xt == 95)) return 8'hFF;
    a = grid_addr(x, y);
    if (a >= 0 && ram_bits[a]) return 8'(sh_rc[(yt - 8) / 2]);
    return 8'h00;
  endfunction

  // driver: check matured expectations, present one pixel, record its expectations
  task automatic step(input int x, input int y);
    logic [9:0] e;
    logic [7:0] e1;
    logic hs, vs;
    int a;
    @(negedge CLK);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check_eq("color", 32'(COLOR), 32'(e[7:0]));
      check_eq("hsync", 32'(HSYNC), 32'(e[8]));
      check_eq("vsync", 32'(VSYNC), 32'(e[9]));
    end
    if (exp1_q.size() >= 1) begin
      e1 = exp1_q.pop_front();
      check_eq("block_addr", 32'(BLOCK_ADDR), 32'(e1[6:0]));
      check_eq("frame_done", 32'(FRAME_DONE), 32'(e1[7]));
    end
    hs = 1'($urandom);
    vs = 1'($urandom);
    X_PIXEL  = 11'(x);
    Y_PIXEL  = 10'(y);
    HSYNC_IN = hs;
    VSYNC_IN = vs;
    if (x == 0 && y == 0) begin
      sh_px = int'(PADDLE_X_PIXEL);
      for (int i = 0; i < NB; i++) begin
        sh_bx[i] = int'(BALL_X_PIXEL[10*i +: 10]);
        sh_by[i] = int'(BALL_Y_PIXEL[10*i +: 10]);
        sh_en[i] = BALL_EN[i];
      end
      for (int r = 0; r < 7; r++) sh_rc[r] = int'(ROW_COLORS[8*r +: 8]);
    end
    a = grid_addr(x, y);
    exp1_q.push_back({(x == 0 && y == 600), (a < 0) ? 7'd0 : 7'(a)});
    exp_q.push_back({vs, hs, model_color(x, y)});
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp1_q.delete();
    sh_px = 0;
    for (int i = 0; i < NB; i++) begin sh_bx[i] = 0; sh_by[i] = 0; sh_en[i] = 1'b0; end
    for (int r = 0; r < 7; r++) sh_rc[r] = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_color"}, 32'(COLOR), 32'd0);
    check_eq({tag, "_hsync"}, 32'(HSYNC), 32'd0);
    check_eq({tag, "_vsync"}, 32'(VSYNC), 32'd0);
    check_eq({tag, "_frame_done"}, 32'(FRAME_DONE), 32'd0);
    check_eq({tag, "_block_addr"}, 32'(BLOCK_ADDR), 32'd0);
  endtask

  // Asynchronous reset in the middle of a clock period.
  task automatic mid_reset();
    #1;
    RESET_N = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    clear_model();
    X_PIXEL = 11'd5;
    Y_PIXEL = 10'd5;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic set_ball(input int i, input int bx, input int by);
    BALL_X_PIXEL[10*i +: 10] = 10'(bx);
    BALL_Y_PIXEL[10*i +: 10] = 10'(by);
  endtask

  initial begin
    int r, bx, by;
    RESET_N = 1'b0;
    X_PIXEL = 11'd5; Y_PIXEL = 10'd5;
    HSYNC_IN = 1'b1; VSYNC_IN = 1'b1;
    PADDLE_X_PIXEL = 10'd300;
    BALL_X_PIXEL = '0; BALL_Y_PIXEL = '0; BALL_EN = '0;
    ROW_COLORS = '0;
    ram_bits = {$urandom, $urandom, $urandom, $urandom};
    clear_model();
    repeat (3) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    @(negedge CLK);
    RESET_N = 1'b1;

    // first frame: balls, blocks and row colours
    for (int k = 0; k < 7; k++) ROW_COLORS[8*k +: 8] = 8'(8'h11 * (k + 1));
    set_ball(0, 100, 200);
    set_ball(1, 100, 100);
    BALL_EN = 2'b11;
    ram_bits[20] = 1'b1;
    ram_bits[69] = 1'b1;
    step(0, 0);
    step(103, 203); step(108, 203); step(103, 103); step(108, 103); step(104, 104);
    step(100, 100); step(107, 107);

    // grid row 6 col 9, alive then dead
    step(616, 160); step(5, 5); step(5, 5);
    ram_bits[69] = 1'b0;
    step(616, 160); step(5, 5);

    // frame done pulse
    step(0, 600); step(1, 600); step(0, 599); step(2, 2);

    // paddle moves mid-frame; shadow holds until next frame start
    step(0, 300);
    PADDLE_X_PIXEL = 10'd400;
    for (int x = 280; x <= 480; x += 4) step(x, 578);
    step(299, 578); step(363, 578); step(364, 578);
    step(0, 0);
    for (int x = 280; x <= 480; x += 4) step(x, 578);
    step(399, 578); step(463, 578); step(464, 578);

    // paddle at the right edge and two overlapping balls
    PADDLE_X_PIXEL = 10'd1000;
    set_ball(0, 500, 500);
    set_ball(1, 504, 503);
    step(0, 0);
    for (int x = 0; x <= 80; x += 2) step(x, 576);
    for (int x = 990; x <= 1055; x += 3) step(x, 580);
    for (int y = 496; y <= 512; y++)
      for (int x = 496; x <= 514; x += 2) step(x, y);

    // reset in the middle of a line
    step(40, 48); step(32, 100);
    mid_reset();
    step(32, 100); step(616, 160); step(40, 48); step(500, 500); step(320, 578);
    step(0, 0); step(500, 500); step(505, 505);

    // randomised stretch
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        PADDLE_X_PIXEL = 10'($urandom_range(0, 1023));
        for (int i = 0; i < NB; i++) set_ball(i, $urandom_range(0, 1023), $urandom_range(0, 620));
        BALL_EN = NB'($urandom);
        ROW_COLORS = {$urandom, $urandom};
      end
      r = $urandom_range(0, 99);
      if (r < 2) step(0, 0);
      else if (r < 4) step(0, 600);
      else if (r < 40) begin
        bx = int'(BALL_X_PIXEL[10*(r % NB) +: 10]);
        by = int'(BALL_Y_PIXEL[10*(r % NB) +: 10]);
        step((bx + $urandom_range(0, 12)) % 1056, (by + $urandom_range(0, 12)) % 628);
      end
      else if (r < 55) step($urandom_range(0, 1055), $urandom_range(576, 583));
      else if (r < 75) step($urandom_range(0, 800), $urandom_range(40, 180));
      else step($urandom_range(0, 1055), $urandom_range(0, 627));
    end
    step(5, 5); step(5, 5); step(5, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
